// File: rtl/uart_tx_core_pkg.sv
// Shared constants, state encodings and the per-frame configuration payload
// for the UART transmitter.
package uart_tx_core_pkg;

  localparam int unsigned WIDTH             = 8;
  localparam int unsigned BIT_COUNTER_WIDTH = $clog2(WIDTH);
  localparam int unsigned PS_WIDTH          = 5;

  // TX state encodings
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Parity type
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Everything latched at accept; the frame in flight depends only on this.
  typedef struct packed {
    logic [WIDTH-1:0]    data;
    logic                par_en;
    logic                par_typ;
    logic [PS_WIDTH-1:0] prescale;
  } tx_cfg_t;

  function automatic logic parity_bit(input logic [WIDTH-1:0] data, input logic par_typ);
    return (par_typ == ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Request/line bundle of the UART transmitter.
//   P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale : request side (master drives)
//   TX_OUT, busy                                   : serial line and status (slave drives)
interface uart_tx_core_if;
  import uart_tx_core_pkg::*;

  logic [WIDTH-1:0]    P_DATA;
  logic                Data_Valid;
  logic                PAR_EN;
  logic                PAR_TYP;
  logic [PS_WIDTH-1:0] Prescale;
  logic                TX_OUT;
  logic                busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy
  );

endinterface

// File: rtl/uart_tx_core_tx_serializer.sv
// Data shift register plus bit counter for the UART transmitter.
//   CLK, RST   : clock, async active-low reset
//   load       : capture data_in, clear bit_cnt
//   shift_en   : move to the next data bit
//   clr        : clear bit_cnt (state change)
//   data_in    : word to serialise
//   shift_lsb  : bit currently on the line
//   shift_nxt  : bit that goes on the line after the next shift
//   bit_cnt    : index of the current data bit
module uart_tx_core_tx_serializer
  import uart_tx_core_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         load,
  input  logic                         shift_en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         shift_lsb,
  output logic                         shift_nxt,
  output logic [BIT_COUNTER_WIDTH-1:0] bit_cnt
);

  logic [WIDTH-1:0]             shift_q;
  logic [BIT_COUNTER_WIDTH-1:0] bit_cnt_q;

  // Load has priority; shift and clear never coincide.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (load) begin
      shift_q   <= data_in;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      shift_q   <= {1'b0, shift_q[WIDTH-1:1]};
      bit_cnt_q <= bit_cnt_q + BIT_COUNTER_WIDTH'(1);
    end else if (clr) begin
      bit_cnt_q <= '0;
    end
  end

  assign shift_lsb = shift_q[0];
  assign shift_nxt = shift_q[1];
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional parity,
// one stop bit; each bit held for Prescale clocks (0 treated as 1).
//   CLK  : clock, rising edge
//   RST  : async active-low reset
//   bus  : uart_tx_core_if.slave (request in, TX_OUT/busy out, both registered)
module uart_tx_core
  import uart_tx_core_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  uart_tx_core_if.slave  bus
);

  logic [2:0]                   state_q, state_d;
  logic [PS_WIDTH-1:0]          edge_cnt_q, edge_cnt_d;
  tx_cfg_t                      cfg_q;
  logic                         tx_q, tx_d;
  logic                         busy_q, busy_d;
  logic                         accept, shift_en, clr;
  logic                         bit_done, last_bit;
  logic                         shift_lsb, shift_nxt;
  logic [BIT_COUNTER_WIDTH-1:0] bit_cnt;
  logic [PS_WIDTH-1:0]          ps_in;

  assign ps_in    = (bus.Prescale == '0) ? PS_WIDTH'(1) : bus.Prescale;
  assign bit_done = (edge_cnt_q == cfg_q.prescale - PS_WIDTH'(1));
  assign last_bit = (bit_cnt == BIT_COUNTER_WIDTH'(WIDTH - 1));

  uart_tx_core_tx_serializer u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .shift_en  (shift_en),
    .clr       (clr),
    .data_in   (bus.P_DATA),
    .shift_lsb (shift_lsb),
    .shift_nxt (shift_nxt),
    .bit_cnt   (bit_cnt)
  );

  // Next state, counter and registered-output values.
  // A request is taken in IDLE or on the last stop cycle, so frames can abut.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q + PS_WIDTH'(1);
    accept     = 1'b0;
    shift_en   = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          if (last_bit) state_d = cfg_q.par_en ? PARITY : STOP;
          else          shift_en = 1'b1;
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (bus.Data_Valid) begin
            accept  = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bit_done || state_q == IDLE) edge_cnt_d = '0;
    clr = (state_d != state_q);

    // Line level for the coming cycle, from the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_en ? shift_nxt : shift_lsb;
      PARITY:  tx_d = parity_bit(cfg_q.data, cfg_q.par_typ);
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      cfg_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      if (accept) begin
        cfg_q <= '{data: bus.P_DATA, par_en: bus.PAR_EN, par_typ: bus.PAR_TYP, prescale: ps_in};
      end
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: stimulus pushes accepted frames into a queue, a
// negedge monitor expands each frame into its ideal per-cycle line waveform
// and compares TX_OUT/busy against it.
module tb_uart_tx_core;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_tx_core_if bus ();

  uart_tx_core dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    int         ps;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   n_pushed   = 0;
  int   n_aborted  = 0;
  int   frames_done = 0;
  int   idle_bad   = 0;
  bit   stim_done  = 0;
  bit   final_done = 0;

  // monitor state
  bit   wave[$];
  bit   active = 0;
  bit   rogue  = 0;
  bit   in_rst = 0;
  int   idx, bad, bad_idx;
  bit   bad_tx, bad_busy, bad_exp;
  exp_t cur;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Reference: line level of every cycle of a frame.
  function automatic void build_wave(input exp_t f);
    bit bits[$];
    int ps;
    ps = (f.ps == 0) ? 1 : f.ps;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
    if (f.pe) bits.push_back((^f.data) ^ f.pt);
    bits.push_back(1'b1);
    wave.delete();
    foreach (bits[i]) for (int c = 0; c < ps; c++) wave.push_back(bits[i]);
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (!in_rst) begin
        in_rst = 1;
        check("reset_tx_out", int'(bus.TX_OUT), 1);
        check("reset_busy", int'(bus.busy), 0);
      end
      n_aborted += exp_q.size() + (active ? 1 : 0);
      exp_q.delete();
      active = 0;
      rogue  = 0;
    end else begin
      in_rst = 0;
      if (!active) begin
        if (bus.busy === 1'b1) begin
          if (exp_q.size() == 0) begin
            if (!rogue) begin
              checks++;
              errors++;
              $display("FAIL unexpected_busy actual busy=1 required busy=0 (no frame requested)");
              rogue = 1;
            end
          end else begin
            cur = exp_q.pop_front();
            build_wave(cur);
            active = 1;
            idx = 0;
            bad = 0;
          end
        end else begin
          rogue = 0;
          if (bus.TX_OUT !== 1'b1) idle_bad++;
        end
      end
      if (active) begin
        if (bus.TX_OUT !== wave[idx] || bus.busy !== 1'b1) begin
          if (bad == 0) begin
            bad_idx  = idx;
            bad_tx   = bus.TX_OUT;
            bad_busy = bus.busy;
            bad_exp  = wave[idx];
          end
          bad++;
        end
        idx++;
        if (idx == wave.size()) begin
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL frame data=%h pe=%0d pt=%0d ps=%0d cycle %0d: actual tx=%b busy=%b, required tx=%b busy=1 (%0d bad cycles)",
                     cur.data, cur.pe, cur.pt, cur.ps, bad_idx, bad_tx, bad_busy, bad_exp, bad);
          end
          active = 0;
          frames_done++;
        end
      end
      if (stim_done && !final_done) begin
        check("queue_drained", exp_q.size() + (active ? 1 : 0), 0);
        check("frames_completed", frames_done, n_pushed - n_aborted);
        check("idle_line_high_cycles_bad", idle_bad, 0);
        check("final_busy", int'(bus.busy), 0);
        final_done = 1;
      end
    end
  end

  task automatic scramble();
    bus.P_DATA   = 8'($urandom);
    bus.PAR_EN   = 1'($urandom);
    bus.PAR_TYP  = 1'($urandom);
    bus.Prescale = 5'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Starts a frame at the next edge and returns one cycle before the edge
  // where a back-to-back frame may be accepted.
  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input logic [4:0] ps,
                      input bit noise, input int pulse_k);
    int psr, len;
    bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.Prescale = ps;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    exp_q.push_back('{data: d, pe: pe, pt: pt, ps: int'(ps)});
    n_pushed++;
    #1;
    bus.Data_Valid = 1'b0;
    scramble();
    psr = (ps == 0) ? 1 : int'(ps);
    len = (10 + int'(pe)) * psr;
    for (int k = 1; k < len; k++) begin
      if (k == pulse_k) begin
        bus.P_DATA = 8'hFF;
        bus.Data_Valid = 1'b1;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        scramble();
        bus.Data_Valid = 1'b1;
      end
      @(posedge CLK);
      #1;
      bus.Data_Valid = 1'b0;
      if (noise) scramble();
    end
  endtask

  initial begin
    repeat (90000) @(posedge CLK);
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.P_DATA = '0; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0; bus.Prescale = '0;
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    idle(2);

    send(8'hA5, 1, 0, 5'd8, 0, 0);   idle(3);
    send(8'h00, 1, 1, 5'd16, 0, 0);  idle(3);
    send(8'h3C, 0, 0, 5'd16, 0, 0);
    send(8'hC3, 0, 0, 5'd16, 0, 0);  idle(2);
    send(8'h12, 0, 0, 5'd8, 0, 20);  idle(2);

    // reset 40 cycles into a frame, then a clean frame
    bus.P_DATA = 8'h66; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Prescale = 5'd8;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    exp_q.push_back('{data: 8'h66, pe: 1'b1, pt: 1'b0, ps: 8});
    n_pushed++;
    #1 bus.Data_Valid = 1'b0;
    repeat (39) @(posedge CLK);
    #3 RST = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    idle(1);
    send(8'h5A, 1, 1, 5'd4, 0, 0);   idle(2);

    send(8'h81, 0, 0, 5'd0, 1, 0);
    send(8'h81, 0, 0, 5'd1, 1, 0);   idle(2);

    for (int n = 0; n < 30; n++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 6)), 1, 0);
      idle($urandom_range(0, 2));
    end

    idle(4);
    stim_done = 1;
    for (int w = 0; w < 20 && !final_done; w++) @(posedge CLK);
    if (!final_done) $display("FAIL final_checks actual=not_run required=run");
    $display("CHECKS %0d ERRORS %0d", checks, errors + (final_done ? 0 : 1));
    $finish;
  end

endmodule
